// File: rtl/frame_deser_pkg.sv
// Shared types and defaults for the frame deserializer.
package frame_deser_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } fsm_state_t;

    localparam int          DEF_WIDTH       = 16;
    localparam logic [15:0] DEF_SYNC_WORD   = 16'hEB90;
    localparam int          DEF_FRAME_WORDS = 8;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frame_deserializer_if.sv
// Bit-slicer input and word-consumer output bundle; master is the deserializer side.
interface frame_deserializer_if #(
    parameter int WIDTH = 16
);
    logic             bit_in;
    logic             bit_en;
    logic             resync;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic             word_sof;
    logic             overrun;
    logic             locked;

    modport master (
        input  bit_in, bit_en, resync, word_ready,
        output word, word_valid, word_sof, overrun, locked
    );

    modport slave (
        output bit_in, bit_en, resync, word_ready,
        input  word, word_valid, word_sof, overrun, locked
    );
endinterface

// File: rtl/frame_deserializer_shift_reg.sv
// Enabled WIDTH-bit shift register; q_next is the value taken on this edge (holds when en=0).
module shift_reg_n
    import frame_deser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit LSB_FIRST = 1'b1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q_next
);
    logic [WIDTH-1:0] q;

    // LSB-first shifts toward bit 0 so the earliest bit ends up in q[0].
    generate
        if (LSB_FIRST) begin : g_lsb
            assign q_next = en ? {din, q[WIDTH-1:1]} : q;
        end else begin : g_msb
            assign q_next = en ? {q[WIDTH-2:0], din} : q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end
endmodule

// File: rtl/frame_deserializer.sv
// Sync hunt (SYNC_DETECT_EN), WIDTH-bit word framing, valid/ready holding register; word_valid one cycle
// after the last bit strobe; a completed word meeting a full, unconsumed register is dropped with an overrun pulse.
module frame_deserializer
    import frame_deser_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEF_SYNC_WORD),
    parameter int               FRAME_WORDS = DEF_FRAME_WORDS,
    parameter bit               LSB_FIRST   = 1'b1
)(
    input  logic                 clk_16,
    input  logic                 reset,
    frame_deserializer_if.master bus
);
    localparam int BW = cnt_width(WIDTH - 1);

    fsm_state_t       state, state_nxt;
    logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
    logic             sof_pend, sof_pend_nxt;
    logic [WIDTH-1:0] sr_next;
    logic             word_done;
    logic             load;
    logic             overrun_nxt;

    logic [WIDTH-1:0] word_q;
    logic             word_valid_q;
    logic             word_sof_q;
    logic             overrun_q;

    shift_reg_n #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_sr (
        .clk   (clk_16),
        .rst_n (reset),
        .en    (bus.bit_en),
        .din   (bus.bit_in),
        .q_next(sr_next)
    );

`ifdef SYNC_DETECT_EN
    localparam int FW = cnt_width(FRAME_WORDS - 1);
    logic [FW-1:0] word_cnt, word_cnt_nxt;

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
        end else begin
            word_cnt <= word_cnt_nxt;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{SYNC_WORD, FRAME_WORDS};
`endif

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        sof_pend_nxt = sof_pend;
        word_done    = 1'b0;
`ifdef SYNC_DETECT_EN
        word_cnt_nxt = word_cnt;
        case (state)
            HUNT: begin
                // sr_next already contains this strobe's bit.
                if (bus.bit_en && (sr_next == SYNC_WORD)) begin
                    state_nxt    = COLLECT;
                    bit_cnt_nxt  = '0;
                    word_cnt_nxt = '0;
                    sof_pend_nxt = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.bit_en) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        word_done   = 1'b1;
                        bit_cnt_nxt = '0;
                        if (word_cnt == FW'(FRAME_WORDS - 1)) begin
                            word_cnt_nxt = '0;
                            state_nxt    = HUNT;
                        end else begin
                            word_cnt_nxt = word_cnt + FW'(1);
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
        if (bus.resync) begin
            state_nxt    = HUNT;
            bit_cnt_nxt  = '0;
            word_cnt_nxt = '0;
            word_done    = 1'b0;
        end
`else
        state_nxt = COLLECT;
        if (bus.bit_en) begin
            if (bit_cnt == BW'(WIDTH - 1)) begin
                word_done   = 1'b1;
                bit_cnt_nxt = '0;
            end else begin
                bit_cnt_nxt = bit_cnt + BW'(1);
            end
        end
        if (bus.resync) begin
            bit_cnt_nxt  = '0;
            sof_pend_nxt = 1'b1;
            word_done    = 1'b0;
        end
`endif
        // A register being consumed this cycle counts as free.
        load        = word_done && (!word_valid_q || bus.word_ready);
        overrun_nxt = word_done && !load;
        if (load) begin
            sof_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            state    <= HUNT;
            bit_cnt  <= '0;
`ifdef SYNC_DETECT_EN
            sof_pend <= 1'b0;
`else
            sof_pend <= 1'b1;
`endif
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sof_pend <= sof_pend_nxt;
        end
    end

    always_ff @(posedge clk_16 or negedge reset) begin
        if (!reset) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_sof_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= overrun_nxt;
            if (load) begin
                word_q       <= sr_next;
                word_sof_q   <= sof_pend;
                word_valid_q <= 1'b1;
            end else if (bus.word_ready) begin
                word_valid_q <= 1'b0;
            end
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_sof   = word_sof_q;
    assign bus.overrun    = overrun_q;
    assign bus.locked     = (state == COLLECT);
endmodule

// File: tb/tb_frame_deserializer.sv
// Randomized bench for frame_deserializer against a bit-stream reference model; follows SYNC_DETECT_EN.
module tb_frame_deserializer;
    import frame_deser_pkg::*;

    localparam int          W    = 16;
    localparam logic [15:0] SYNC = 16'hEB90;
    localparam int          FW   = 8;

    logic clk_16;
    logic reset;

    initial clk_16 = 1'b0;
    always #5 clk_16 = ~clk_16;

    frame_deserializer_if #(.WIDTH(W)) bus();

    frame_deserializer #(
        .WIDTH      (W),
        .SYNC_WORD  (SYNC),
        .FRAME_WORDS(FW),
        .LSB_FIRST  (1'b1)
    ) dut (
        .clk_16(clk_16),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: arrival-order bit history and stream counts.
    logic [W-1:0] m_hist;
    int           m_nbits;
    int           m_nwords;
    bit           m_locked;
    bit           m_sof_pend;
    bit           m_valid;
    bit           m_sof;
    bit           m_ovr;
    logic [W-1:0] m_word;
    logic [W:0]   exp_q[$];
    logic [W:0]   obs_q[$];
    int           exp_ovr;
    int           obs_ovr;
    bit           prev_valid;

    // m_hist[0] is the newest bit; the oldest of the last W bits goes to word[0].
    function automatic logic [W-1:0] assemble(input logic [W-1:0] h);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = h[W-1-i];
        return r;
    endfunction

    function automatic void model_reset();
        m_hist = '0; m_nbits = 0; m_nwords = 0; m_locked = 0;
        m_valid = 0; m_sof = 0; m_ovr = 0; m_word = '0;
`ifdef SYNC_DETECT_EN
        m_sof_pend = 0;
`else
        m_sof_pend = 1;
`endif
        exp_q.delete(); obs_q.delete();
        exp_ovr = 0; obs_ovr = 0; prev_valid = 0;
    endfunction

    function automatic void model_step(input bit en, input bit b, input bit rs, input bit rdy);
        bit done = 0;
        if (en) m_hist = {m_hist[W-2:0], b};
        if (rs) begin
            m_nbits = 0; m_nwords = 0;
`ifdef SYNC_DETECT_EN
            m_locked = 0;
`else
            m_sof_pend = 1;
`endif
        end else if (en) begin
`ifdef SYNC_DETECT_EN
            if (!m_locked) begin
                if (assemble(m_hist) == SYNC) begin
                    m_locked = 1; m_nbits = 0; m_nwords = 0; m_sof_pend = 1;
                end
            end else begin
                m_nbits++;
                if (m_nbits % W == 0) begin
                    done = 1;
                    m_nwords++;
                    if (m_nwords == FW) m_locked = 0;
                end
            end
`else
            m_nbits++;
            if (m_nbits % W == 0) begin
                done = 1;
                m_nwords++;
            end
`endif
        end
`ifndef SYNC_DETECT_EN
        m_locked = 1;
`endif
        m_ovr = 0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_word = assemble(m_hist);
                m_sof = m_sof_pend;
                m_sof_pend = 0;
                m_valid = 1;
                exp_q.push_back({m_sof, m_word});
            end else begin
                m_ovr = 1;
                exp_ovr++;
            end
        end else if (rdy) begin
            m_valid = 0;
        end
    endfunction

    // One clock: drive, step model at the edge, sample 1ns later and log presented words.
    task automatic cycle(input bit en, input bit b, input bit rs, input bit rdy);
        bus.bit_en = en; bus.bit_in = b; bus.resync = rs; bus.word_ready = rdy;
        @(posedge clk_16);
        model_step(en, b, rs, rdy);
        #1;
        if (bus.word_valid && (!prev_valid || rdy)) obs_q.push_back({bus.word_sof, bus.word});
        if (bus.overrun) obs_ovr++;
        prev_valid = bus.word_valid;
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int n, input bit rdy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 1'($urandom), 1'b0, rdy);
            cycle(1'b1, v[i], 1'b0, rdy);
        end
    endtask

    task automatic send_sync_prefix(input bit rdy);
`ifdef SYNC_DETECT_EN
        send_bits(SYNC, W, rdy, 1'b0);
`else
        cycle(1'b0, 1'b0, 1'b0, rdy);
`endif
    endtask

    task automatic do_reset();
        bus.bit_en = 0; bus.bit_in = 0; bus.resync = 0; bus.word_ready = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk_16);
        model_reset();
        @(negedge clk_16);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.resync = 0; bus.word_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_16);
            bus.bit_en = 1'b1;
            bus.bit_in = i[0];
        end
        @(negedge clk_16);
        n_checks++; if (bus.word !== '0) begin n_fail++; $display("FAIL reset_word: got %h expected 0", bus.word); end
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.word_valid); end
        n_checks++; if (bus.word_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof: got %b expected 0", bus.word_sof); end
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        bus.bit_en = 1'b0;
        model_reset();
        reset = 1'b1;
        #1;
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL release_locked: got %b expected 0", bus.locked); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL release_locked_next: got %b expected %b", bus.locked, m_locked); end
    endtask

    task automatic test_sync_lock();
        logic [W-1:0] s = SYNC;
        logic [W-1:0] d = 16'h1234;
        do_reset();
`ifdef SYNC_DETECT_EN
        send_bits(s, W - 1, 1'b1, 1'b0);
        n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL sync_pre_lock: got %b expected %b", bus.locked, m_locked); end
        cycle(1'b1, s[W-1], 1'b0, 1'b1);
`else
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif
        n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL sync_lock: got %b expected %b", bus.locked, m_locked); end
        send_bits(d, W - 1, 1'b1, 1'b0);
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL sync_early_valid: got %b expected 0", bus.word_valid); end
        cycle(1'b1, d[W-1], 1'b0, 1'b1);
        n_checks++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL sync_word_valid: got %b expected 1", bus.word_valid); end
        n_checks++; if (bus.word !== 16'h1234) begin n_fail++; $display("FAIL sync_word: got %h expected 1234", bus.word); end
        n_checks++; if (bus.word_sof !== 1'b1) begin n_fail++; $display("FAIL sync_sof: got %b expected 1", bus.word_sof); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL sync_valid_drop: got %b expected 0", bus.word_valid); end
    endtask

    task automatic test_near_miss();
        bit saw_lock = 0;
        bit exp_lock = 0;
        logic [W-1:0] pat [3];
        pat[0] = 16'hEB91; pat[1] = 16'h1234; pat[2] = 16'h5678;
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < W; i++) begin
                cycle(1'b1, pat[w][i], 1'b0, 1'b1);
                saw_lock |= bus.locked;
                exp_lock |= m_locked;
            end
        end
        n_checks++; if (saw_lock !== exp_lock) begin n_fail++; $display("FAIL near_miss_lock: got %b expected %b", saw_lock, exp_lock); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL near_miss_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL near_miss_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_sync_prefix(1'b0);
        send_bits(16'hAAAA, W, 1'b0, 1'b0);
        n_checks++; if (bus.word !== 16'hAAAA || bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got %h/%b expected aaaa/1", bus.word, bus.word_valid); end
        send_bits(16'h5555, W, 1'b0, 1'b0);
        n_checks++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun_pulse: got %b expected 1", bus.overrun); end
        n_checks++; if (bus.word !== 16'hAAAA || bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %h/%b expected aaaa/1", bus.word, bus.word_valid); end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_width: got %b expected 0", bus.overrun); end
        n_checks++; if (obs_ovr != 1 || exp_ovr != 1) begin n_fail++; $display("FAIL bp_overrun_count: got %0d expected 1 (model %0d)", obs_ovr, exp_ovr); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consume: got %b expected 0", bus.word_valid); end
    endtask

    task automatic test_frame_end();
        int sofs = 0;
        do_reset();
        send_sync_prefix(1'b1);
        for (int w = 0; w < FW; w++) begin
            logic [W-1:0] v = W'($urandom);
            for (int i = 0; i < W; i++) begin
                cycle(1'b1, v[i], 1'b0, 1'b1);
                n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL frame_locked w%0d b%0d: got %b expected %b", w, i, bus.locked, m_locked); end
            end
        end
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, 1'($urandom), 1'b0, 1'b1);
            n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL frame_tail_locked b%0d: got %b expected %b", i, bus.locked, m_locked); end
        end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL frame_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        foreach (obs_q[i]) if (obs_q[i][W]) sofs++;
        n_checks++; if (sofs != 1 || obs_q.size() == 0 || obs_q[0][W] !== 1'b1) begin n_fail++; $display("FAIL frame_sof: got %0d sof words expected 1 on first", sofs); end
    endtask

    task automatic test_resync_and_reset();
        do_reset();
        send_sync_prefix(1'b1);
        send_bits(W'($urandom), 5, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL resync_locked: got %b expected %b", bus.locked, m_locked); end
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (obs_q.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL resync_no_word: got %0d expected 0", obs_q.size()); end
        send_sync_prefix(1'b1);
        send_bits(16'h0F0F, W, 1'b1, 1'b0);
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL resync_count: got %0d expected 1", obs_q.size()); end
        else if (obs_q[0] !== {1'b1, 16'h0F0F}) begin n_fail++; $display("FAIL resync_word: got %h expected 10f0f", obs_q[0]); end
        send_bits(W'($urandom), 7, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({bus.word, bus.word_valid, bus.word_sof, bus.overrun, bus.locked} !== '0) begin
            n_fail++; $display("FAIL async_reset: got %h/%b/%b/%b/%b expected all 0", bus.word, bus.word_valid, bus.word_sof, bus.overrun, bus.locked);
        end
        model_reset();
        @(negedge clk_16);
        reset = 1'b1;
        #1;
        send_bits(16'h1234, W, 1'b1, 1'b0);
        n_checks++; if (bus.locked !== m_locked) begin n_fail++; $display("FAIL rehunt_locked: got %b expected %b", bus.locked, m_locked); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rehunt_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rehunt_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random_stream();
        bit bits[$];
        do_reset();
        for (int f = 0; f < 3; f++) begin
            logic [W-1:0] s = SYNC;
            for (int i = 0; i < W; i++) bits.push_back(s[i]);
            for (int w = 0; w < FW; w++) begin
                logic [W-1:0] v = W'($urandom);
                for (int i = 0; i < W; i++) bits.push_back(v[i]);
            end
        end
        for (int k = 0; k < bits.size(); k++) begin
            int g = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int s = 0; s <= g; s++) begin
                bit en = (s == g);
                cycle(en, en ? bits[k] : 1'b0, $urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
                n_checks++;
                if ({bus.word, bus.word_valid, bus.word_sof, bus.overrun, bus.locked} !== {m_word, m_valid, m_sof, m_ovr, m_locked}) begin
                    n_fail++;
                    $display("FAIL random_cycle bit%0d: got %h expected %h", k,
                             {bus.word, bus.word_valid, bus.word_sof, bus.overrun, bus.locked},
                             {m_word, m_valid, m_sof, m_ovr, m_locked});
                end
            end
        end
        n_checks++; if (obs_ovr != exp_ovr) begin n_fail++; $display("FAIL random_overruns: got %0d expected %0d", obs_ovr, exp_ovr); end
    endtask

    initial begin
        reset = 1'b0;
        bus.bit_en = 0; bus.bit_in = 0; bus.resync = 0; bus.word_ready = 0;
        model_reset();
        test_reset();
        test_sync_lock();
        test_near_miss();
        test_backpressure();
        test_frame_end();
        test_resync_and_reset();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
